fp_add_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor. Next generation of the combinational single-precision adder in the ALU754 datapath.
- Adds a valid/ready handshake, a 3-stage pipeline, round-to-nearest-even, special-value handling and per-result exception flags.
- Sits between the ALU operand registers and the result writeback stage.

---
 rtl/fp_add_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - three-stage pipelined IEEE-754 adder/subtractor with RNE rounding
// Stages: align (S1), add (S2), normalise/round/pack (S3); one global advance enable.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid,
    output logic         inexact
);
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW + 1);
    localparam int EW  = EXP_W + LZW + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    function automatic logic [LZW-1:0] f_lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = LZW'(SW - 1 - i);
        end
        return n;
    endfunction

    logic r1_valid, r1_spec, r1_inv, r1_sign, r1_esub;
    logic [W-1:0] r1_spec_val;
    logic [EXP_W-1:0] r1_exp;
    logic [SW-1:0] r1_xm, r1_ym;
    logic r2_valid, r2_spec, r2_inv, r2_sign;
    logic [W-1:0] r2_spec_val;
    logic [EXP_W-1:0] r2_exp;
    logic [SW:0] r2_sum;
    logic r3_valid;
    logic w_en;

    assign w_en      = ~r3_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r3_valid;

    // S1: classify, flush denormals, order by magnitude, align the smaller operand
    logic w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_swap;
    logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey, w_diff;
    logic [MAN_W-1:0] w_fa, w_fb, w_fx, w_fy;
    logic [W-2:0] w_a_mag, w_b_mag;
    logic [SW-1:0] w_ym, w_ysh, w_yal;
    logic w_lost, w_spec, w_spec_inv;
    logic [W-1:0] w_spec_val;

    assign w_sa     = a[W-1];
    assign w_sb     = b[W-1] ^ sub;
    assign w_ea     = a[W-2:MAN_W];
    assign w_eb     = b[W-2:MAN_W];
    assign w_fa     = a[MAN_W-1:0];
    assign w_fb     = b[MAN_W-1:0];
    assign w_a_nan  = (&w_ea) & (|w_fa);
    assign w_b_nan  = (&w_eb) & (|w_fb);
    assign w_a_inf  = (&w_ea) & ~(|w_fa);
    assign w_b_inf  = (&w_eb) & ~(|w_fb);
    assign w_a_zero = ~(|w_ea);
    assign w_b_zero = ~(|w_eb);
    assign w_a_mag  = w_a_zero ? '0 : a[W-2:0];
    assign w_b_mag  = w_b_zero ? '0 : b[W-2:0];
    assign w_swap   = w_b_mag > w_a_mag;
    assign w_ex     = w_swap ? w_eb : w_ea;
    assign w_fx     = w_swap ? w_fb : w_fa;
    assign w_ey     = w_swap ? w_ea : w_eb;
    assign w_fy     = w_swap ? w_fa : w_fb;
    assign w_diff   = w_ex - w_ey;
    assign w_ym     = {1'b1, w_fy, 3'b000};
    assign w_ysh    = w_ym >> w_diff;
    assign w_lost   = |(w_ym & ~({SW{1'b1}} << w_diff));
    assign w_yal    = {w_ysh[SW-1:1], w_ysh[0] | w_lost};

    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_val = '0;
        if (w_a_nan | w_b_nan) begin
            w_spec_val = QNAN;
        end else if (w_a_inf & w_b_inf & (w_sa != w_sb)) begin
            w_spec_val = QNAN;
            w_spec_inv = 1'b1;
        end else if (w_a_inf) begin
            w_spec_val = {w_sa, a[W-2:0]};
        end else if (w_b_inf) begin
            w_spec_val = {w_sb, b[W-2:0]};
        end else if (w_a_zero & w_b_zero) begin
            w_spec_val = {w_sa & w_sb, {(W-1){1'b0}}};
        end else if (w_a_zero) begin
            w_spec_val = {w_sb, b[W-2:0]};
        end else if (w_b_zero) begin
            w_spec_val = a;
        end else begin
            w_spec = 1'b0;
        end
    end

    // S3: normalise, round to nearest even, detect range limits
    logic [LZW-1:0] w_lzc;
    logic [SW-1:0] w_norm;
    logic signed [EW-1:0] w_exp_e, w_exp_n, w_exp_r;
    logic [MAN_W:0] w_mant;
    logic [MAN_W+1:0] w_rnd;
    logic w_g, w_r, w_st, w_up;
    logic [W-1:0] w_res;
    logic w_of, w_uf, w_ix;

    assign w_lzc   = f_lzc(r2_sum[SW-1:0]);
    assign w_exp_e = $signed({{(EW-EXP_W){1'b0}}, r2_exp});

    always_comb begin
        if (r2_sum[SW]) begin
            w_norm  = {r2_sum[SW:2], r2_sum[1] | r2_sum[0]};
            w_exp_n = w_exp_e + EW'(1);
        end else begin
            w_norm  = r2_sum[SW-1:0] << w_lzc;
            w_exp_n = w_exp_e - $signed({{(EW-LZW){1'b0}}, w_lzc});
        end
        w_mant  = w_norm[SW-1:3];
        w_g     = w_norm[2];
        w_r     = w_norm[1];
        w_st    = w_norm[0];
        w_up    = w_g & (w_r | w_st | w_mant[0]);
        w_rnd   = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_up};
        w_exp_r = w_exp_n + {{(EW-1){1'b0}}, w_rnd[MAN_W+1]};
        w_res   = '0;
        w_of    = 1'b0;
        w_uf    = 1'b0;
        w_ix    = 1'b0;
        if (r2_spec) begin
            w_res = r2_spec_val;
        end else if (r2_sum == '0) begin
            w_res = '0;
        end else if (w_exp_n <= 0) begin
            w_res = {r2_sign, {(W-1){1'b0}}};
            w_uf  = 1'b1;
            w_ix  = 1'b1;
        end else if (w_exp_r >= EMAX) begin
            w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_of  = 1'b1;
            w_ix  = 1'b1;
        end else begin
            w_res = {r2_sign, w_exp_r[EXP_W-1:0], w_rnd[MAN_W-1:0]};
            w_ix  = w_g | w_r | w_st;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid    <= 1'b0;
            r1_spec     <= 1'b0;
            r1_inv      <= 1'b0;
            r1_sign     <= 1'b0;
            r1_esub     <= 1'b0;
            r1_spec_val <= '0;
            r1_exp      <= '0;
            r1_xm       <= '0;
            r1_ym       <= '0;
            r2_valid    <= 1'b0;
            r2_spec     <= 1'b0;
            r2_inv      <= 1'b0;
            r2_sign     <= 1'b0;
            r2_spec_val <= '0;
            r2_exp      <= '0;
            r2_sum      <= '0;
            r3_valid    <= 1'b0;
            s           <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            invalid     <= 1'b0;
            inexact     <= 1'b0;
        end else if (w_en) begin
            r1_valid    <= in_valid;
            r1_spec     <= w_spec;
            r1_inv      <= w_spec_inv;
            r1_spec_val <= w_spec_val;
            r1_sign     <= w_swap ? w_sb : w_sa;
            r1_esub     <= w_sa ^ w_sb;
            r1_exp      <= w_ex;
            r1_xm       <= {1'b1, w_fx, 3'b000};
            r1_ym       <= w_yal;
            r2_valid    <= r1_valid;
            r2_spec     <= r1_spec;
            r2_inv      <= r1_inv;
            r2_spec_val <= r1_spec_val;
            r2_sign     <= r1_sign;
            r2_exp      <= r1_exp;
            r2_sum      <= r1_esub ? ({1'b0, r1_xm} - {1'b0, r1_ym})
                                   : ({1'b0, r1_xm} + {1'b0, r1_ym});
            r3_valid    <= r2_valid;
            s           <= w_res;
            overflow    <= w_of;
            underflow   <= w_uf;
            invalid     <= r2_spec & r2_inv;
            inexact     <= w_ix;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - directed self-checking bench for fp_add_pipe
module tb_fp_add_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic sub = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [31:0] s;
    logic overflow, underflow, invalid, inexact;
    int checks = 0;
    int errors = 0;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .overflow(overflow), .underflow(underflow), .invalid(invalid),
        .inexact(inexact)
    );

    always #5 clk = ~clk;

    // Flags packed as {overflow, underflow, invalid, inexact}.
    task automatic op(input logic [31:0] ta, input logic [31:0] tb, input logic tsub,
                      output logic [31:0] rs, output logic [3:0] rf, output int lat);
        @(negedge clk);
        a = ta; b = tb; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rs = s;
        rf = {overflow, underflow, invalid, inexact};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (s !== 32'h0) begin errors++; $display("FAIL reset_s got=%h exp=00000000", s); end
        checks++; if ({overflow, underflow, invalid, inexact} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {overflow, underflow, invalid, inexact}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] rs; logic [3:0] rf; int lat;
        op(32'h3F800000, 32'h40000000, 1'b0, rs, rf, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++; if (rs !== 32'h40400000) begin errors++; $display("FAIL basic_add got=%h exp=40400000", rs); end
        checks++; if (rf !== 4'b0000) begin errors++; $display("FAIL basic_add_flags got=%b exp=0000", rf); end
        op(32'h3F800000, 32'h40000000, 1'b1, rs, rf, lat);
        checks++; if (rs !== 32'hBF800000) begin errors++; $display("FAIL basic_sub got=%h exp=BF800000", rs); end
        checks++; if (rf !== 4'b0000) begin errors++; $display("FAIL basic_sub_flags got=%b exp=0000", rf); end
    endtask

    task automatic test_round();
        logic [31:0] rs; logic [3:0] rf; int lat;
        op(32'h3F800000, 32'h33800000, 1'b0, rs, rf, lat);
        checks++; if (rs !== 32'h3F800000) begin errors++; $display("FAIL round_tie got=%h exp=3F800000", rs); end
        checks++; if (rf !== 4'b0001) begin errors++; $display("FAIL round_tie_flags got=%b exp=0001", rf); end
        op(32'h3F800000, 32'h33800001, 1'b0, rs, rf, lat);
        checks++; if (rs !== 32'h3F800001) begin errors++; $display("FAIL round_up got=%h exp=3F800001", rs); end
        checks++; if (rf !== 4'b0001) begin errors++; $display("FAIL round_up_flags got=%b exp=0001", rf); end
        op(32'h3F800000, 32'h3F800000, 1'b1, rs, rf, lat);
        checks++; if (rs !== 32'h00000000) begin errors++; $display("FAIL cancel got=%h exp=00000000", rs); end
        checks++; if (rf !== 4'b0000) begin errors++; $display("FAIL cancel_flags got=%b exp=0000", rf); end
        op(32'h80000000, 32'h80000000, 1'b0, rs, rf, lat);
        checks++; if (rs !== 32'h80000000) begin errors++; $display("FAIL negzero got=%h exp=80000000", rs); end
    endtask

    task automatic test_range();
        logic [31:0] rs; logic [3:0] rf; int lat;
        op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, rs, rf, lat);
        checks++; if (rs !== 32'h7F800000) begin errors++; $display("FAIL overflow_s got=%h exp=7F800000", rs); end
        checks++; if (rf !== 4'b1001) begin errors++; $display("FAIL overflow_flags got=%b exp=1001", rf); end
        op(32'h00800001, 32'h00800000, 1'b1, rs, rf, lat);
        checks++; if (rs !== 32'h00000000) begin errors++; $display("FAIL underflow_s got=%h exp=00000000", rs); end
        checks++; if (rf !== 4'b0101) begin errors++; $display("FAIL underflow_flags got=%b exp=0101", rf); end
    endtask

    task automatic test_specials();
        logic [31:0] rs; logic [3:0] rf; int lat;
        op(32'h7F800000, 32'h7F800000, 1'b1, rs, rf, lat);
        checks++; if (rs !== 32'h7FC00000) begin errors++; $display("FAIL inf_minus_inf got=%h exp=7FC00000", rs); end
        checks++; if (rf !== 4'b0010) begin errors++; $display("FAIL inf_minus_inf_flags got=%b exp=0010", rf); end
        op(32'h7FC12345, 32'h3F800000, 1'b0, rs, rf, lat);
        checks++; if (rs !== 32'h7FC00000) begin errors++; $display("FAIL nan_in got=%h exp=7FC00000", rs); end
        checks++; if (rf !== 4'b0000) begin errors++; $display("FAIL nan_in_flags got=%b exp=0000", rf); end
        op(32'h7F800000, 32'h3F800000, 1'b0, rs, rf, lat);
        checks++; if (rs !== 32'h7F800000) begin errors++; $display("FAIL inf_plus_one got=%h exp=7F800000", rs); end
        checks++; if (rf !== 4'b0000) begin errors++; $display("FAIL inf_plus_one_flags got=%b exp=0000", rf); end
        op(32'h3F800000, 32'h00400000, 1'b1, rs, rf, lat);
        checks++; if (rs !== 32'h3F800000) begin errors++; $display("FAIL denorm_flush got=%h exp=3F800000", rs); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'hC0000000, 32'h41200000};
        logic [31:0] vb [6] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h40A00000};
        logic vs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ve [6] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h3F800000, 32'hBF800000, 32'h41700000};
        logic [31:0] got [6];
        logic [31:0] held;
        int idx, n_got, stall_left, cyc;
        bit seen;
        idx = 0; n_got = 0; stall_left = 0; cyc = 0; seen = 1'b0; held = '0;
        while (n_got < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 4;
                held = s;
            end
            out_ready = (stall_left == 0);
            if (idx < 6) begin
                in_valid = 1'b1; a = va[idx]; b = vb[idx]; sub = vs[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                checks++; if (s !== held || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/1", cyc, s, out_valid, held); end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                got[n_got] = s;
                n_got++;
            end
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (n_got !== 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", n_got); end
        for (int i = 0; i < n_got; i++) begin
            checks++; if (got[i] !== ve[i]) begin errors++; $display("FAIL b2b_result%0d got=%h exp=%h", i, got[i], ve[i]); end
        end
        repeat (4) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got=%b exp=0", out_valid); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rs; logic [3:0] rf; int lat;
        bit emerged;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h40000000; b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
        checks++; if (s !== 32'h0) begin errors++; $display("FAIL arst_s got=%h exp=00000000", s); end
        #4 rst_n = 1'b1;
        emerged = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) emerged = 1'b1;
        end
        checks++; if (emerged !== 1'b0) begin errors++; $display("FAIL arst_ghost got=%b exp=0", emerged); end
        op(32'h41200000, 32'h40A00000, 1'b1, rs, rf, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL arst_latency got=%0d exp=3", lat); end
        checks++; if (rs !== 32'h40A00000) begin errors++; $display("FAIL arst_result got=%h exp=40A00000", rs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_range();
        test_specials();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
